// File: rtl/gf180mcu_ocd_io__seq_pkg.sv
// Shared definitions for the GF180MCU I/O-ring supply sequencer.
//   seq_state_e : sequencer FSM states
//   FAULT_IDX_W : width of the faulting-domain index (covers up to 16 domains)
//   cnt_w()     : shared counter width, sized for the longest interval plus one bit
package gf180mcu_ocd_io__seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_UP_WAIT,
    ST_UP_SETTLE,
    ST_ON,
    ST_DOWN,
    ST_FAULT
  } seq_state_e;

  localparam int FAULT_IDX_W = 4;

  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__sync2.sv
// Two-flop synchroniser used to bring the asynchronous per-domain power-good
// inputs into the sequencer clock domain.
//   CLK  : destination clock
//   RST  : synchronous active-high reset, clears both flop stages
//   i_d  : asynchronous input bus (W bits)
//   o_q  : synchronised output bus (W bits), 2 cycles of latency
module gf180mcu_ocd_io__sync2 #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/gf180mcu_ocd_io__supply_seq.sv
// Supply-domain sequencer for the GF180MCU pad ring. Powers domains up in
// ascending order (enable, wait for power-good, settle), powers them down in
// descending order, and performs a one-edge emergency shutdown on timeout or
// lost power-good, latching the faulting domain until cleared with EN low.
//   CLK, RST   : clock and synchronous active-high reset
//   EN         : level request, 1 = ring powered
//   CLR        : single-cycle fault clear, only honoured while EN=0
//   PG         : per-domain power-good (asynchronous)
//   PWR_EN     : per-domain supply enable
//   READY      : all domains up and settled
//   FAULT      : latched fault flag
//   FAULT_IDX  : index of the faulting domain
//   ISO        : per-domain isolation, only with GF180MCU_OCD_IO_SEQ_ISO_EN
// Optional macro: GF180MCU_OCD_IO_SEQ_ISO_EN adds the ISO output and an extra
// isolate-before-disable cycle per domain on power-down.
module gf180mcu_ocd_io__supply_seq
  import gf180mcu_ocd_io__seq_pkg::*;
#(
  parameter int N_DOM       = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int OFF_CYC     = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   CLR,
  input  logic [N_DOM-1:0]       PG,
  output logic [N_DOM-1:0]       PWR_EN,
  output logic                   READY,
  output logic                   FAULT,
  output logic [FAULT_IDX_W-1:0] FAULT_IDX
`ifdef GF180MCU_OCD_IO_SEQ_ISO_EN
  ,
  output logic [N_DOM-1:0]       ISO
`endif
);

  localparam int CW = cnt_w(SETTLE_CYC, TIMEOUT_CYC, OFF_CYC);
  localparam logic [CW-1:0]          SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]          TO_LAST     = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]          OFF_LAST    = CW'(OFF_CYC - 1);
  localparam logic [FAULT_IDX_W-1:0] LAST_IDX    = FAULT_IDX_W'(N_DOM - 1);

  seq_state_e             r_state, w_state_nxt;
  logic [FAULT_IDX_W-1:0] r_idx, w_idx_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [N_DOM-1:0]       r_pwr_en, w_pwr_en_nxt;
  logic                   r_ready, w_ready_nxt;
  logic                   r_fault, w_fault_nxt;
  logic [FAULT_IDX_W-1:0] r_fault_idx, w_fault_idx_nxt;
`ifdef GF180MCU_OCD_IO_SEQ_ISO_EN
  logic [N_DOM-1:0]       r_iso, w_iso_nxt;
`endif

  logic [N_DOM-1:0]       w_pg_s;
  logic [N_DOM-1:0]       w_mask;
  logic                   w_pg_cur;
  logic                   w_pg_all;
  logic [FAULT_IDX_W-1:0] w_low_j;
  logic                   w_do_fault;
  logic                   w_do_down;
  logic [FAULT_IDX_W-1:0] w_fault_src;

  gf180mcu_ocd_io__sync2 #(.W(N_DOM)) u_pg_sync (
    .CLK (CLK),
    .RST (RST),
    .i_d (PG),
    .o_q (w_pg_s)
  );

  // One-hot select of the current domain avoids variable bit-selects.
  assign w_mask   = N_DOM'(1) << r_idx;
  assign w_pg_cur = |(w_pg_s & w_mask);
  assign w_pg_all = &w_pg_s;

  // Lowest domain that has lost power-good (scanned high to low so the
  // lowest index wins).
  always_comb begin
    w_low_j = '0;
    for (int j = N_DOM - 1; j >= 0; j--) begin
      if (!w_pg_s[j]) w_low_j = FAULT_IDX_W'(j);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_pwr_en_nxt    = r_pwr_en;
    w_ready_nxt     = r_ready;
    w_fault_nxt     = r_fault;
    w_fault_idx_nxt = r_fault_idx;
`ifdef GF180MCU_OCD_IO_SEQ_ISO_EN
    w_iso_nxt       = r_iso;
`endif
    w_do_fault      = 1'b0;
    w_do_down       = 1'b0;
    w_fault_src     = r_idx;

    case (r_state)
      ST_OFF: begin
        if (EN) begin
          w_pwr_en_nxt = N_DOM'(1);
          w_idx_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_UP_WAIT;
        end
      end
      ST_UP_WAIT: begin
        w_cnt_nxt = r_cnt + CW'(1);
        // Power-good arriving on the last allowed cycle still counts as good.
        if (!w_pg_cur && r_cnt == TO_LAST) begin
          w_do_fault = 1'b1;
        end else if (!EN) begin
          w_do_down = 1'b1;
        end else if (w_pg_cur) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_UP_SETTLE;
        end
      end
      ST_UP_SETTLE: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (!w_pg_cur) begin
          w_do_fault = 1'b1;
        end else if (!EN) begin
          w_do_down = 1'b1;
        end else if (r_cnt == SETTLE_LAST) begin
          w_cnt_nxt = '0;
`ifdef GF180MCU_OCD_IO_SEQ_ISO_EN
          w_iso_nxt = r_iso & ~w_mask;
`endif
          if (r_idx == LAST_IDX) begin
            w_ready_nxt = 1'b1;
            w_state_nxt = ST_ON;
          end else begin
            w_idx_nxt    = r_idx + FAULT_IDX_W'(1);
            w_pwr_en_nxt = r_pwr_en | (w_mask << 1);
            w_state_nxt  = ST_UP_WAIT;
          end
        end
      end
      ST_ON: begin
        if (!w_pg_all) begin
          w_do_fault  = 1'b1;
          w_fault_src = w_low_j;
        end else if (!EN) begin
          w_ready_nxt = 1'b0;
          w_do_down   = 1'b1;
        end
      end
      ST_DOWN: begin
`ifdef GF180MCU_OCD_IO_SEQ_ISO_EN
        // Domain still enabled means its isolation went up last edge:
        // drop the enable now, then start the inter-domain gap.
        if (|(r_pwr_en & w_mask)) begin
          w_pwr_en_nxt = r_pwr_en & ~w_mask;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == OFF_LAST) begin
            w_cnt_nxt = '0;
            if (r_idx == '0) begin
              w_state_nxt = ST_OFF;
            end else begin
              w_idx_nxt = r_idx - FAULT_IDX_W'(1);
              w_iso_nxt = r_iso | (w_mask >> 1);
            end
          end
        end
`else
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == OFF_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == '0) begin
            w_state_nxt = ST_OFF;
          end else begin
            w_idx_nxt    = r_idx - FAULT_IDX_W'(1);
            w_pwr_en_nxt = r_pwr_en & ~(w_mask >> 1);
          end
        end
`endif
      end
      ST_FAULT: begin
        if (CLR && !EN) begin
          w_fault_nxt     = 1'b0;
          w_fault_idx_nxt = '0;
          w_idx_nxt       = '0;
          w_cnt_nxt       = '0;
          w_state_nxt     = ST_OFF;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase

    // Power-down starts from the highest domain currently enabled.
    if (w_do_down) begin
      w_cnt_nxt   = '0;
      w_state_nxt = ST_DOWN;
`ifdef GF180MCU_OCD_IO_SEQ_ISO_EN
      w_iso_nxt   = r_iso | w_mask;
`else
      w_pwr_en_nxt = r_pwr_en & ~w_mask;
`endif
    end

    // Emergency shutdown: every enable drops in the same edge.
    if (w_do_fault) begin
      w_pwr_en_nxt    = '0;
      w_ready_nxt     = 1'b0;
      w_fault_nxt     = 1'b1;
      w_fault_idx_nxt = w_fault_src;
      w_cnt_nxt       = '0;
      w_state_nxt     = ST_FAULT;
`ifdef GF180MCU_OCD_IO_SEQ_ISO_EN
      w_iso_nxt       = '1;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_OFF;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pwr_en    <= '0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
      r_fault_idx <= '0;
`ifdef GF180MCU_OCD_IO_SEQ_ISO_EN
      r_iso       <= '1;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pwr_en    <= w_pwr_en_nxt;
      r_ready     <= w_ready_nxt;
      r_fault     <= w_fault_nxt;
      r_fault_idx <= w_fault_idx_nxt;
`ifdef GF180MCU_OCD_IO_SEQ_ISO_EN
      r_iso       <= w_iso_nxt;
`endif
    end
  end

  assign PWR_EN    = r_pwr_en;
  assign READY     = r_ready;
  assign FAULT     = r_fault;
  assign FAULT_IDX = r_fault_idx;
`ifdef GF180MCU_OCD_IO_SEQ_ISO_EN
  assign ISO       = r_iso;
`endif

endmodule

// File: tb/tb_gf180mcu_ocd_io__supply_seq.sv
// Directed bench for the supply sequencer with N_DOM=2, SETTLE_CYC=4,
// TIMEOUT_CYC=16, OFF_CYC=3. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point.
module tb_gf180mcu_ocd_io__supply_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b0;
  logic       CLR = 1'b0;
  logic [1:0] PG  = 2'b11;
  logic [1:0] PWR_EN;
  logic       READY;
  logic       FAULT;
  logic [3:0] FAULT_IDX;

  int total = 0;
  int bad   = 0;

  gf180mcu_ocd_io__supply_seq #(
    .N_DOM       (2),
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (16),
    .OFF_CYC     (3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .CLR       (CLR),
    .PG        (PG),
    .PWR_EN    (PWR_EN),
    .READY     (READY),
    .FAULT     (FAULT),
    .FAULT_IDX (FAULT_IDX)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    tick(1);
    check("rst_pwr_en", 32'(PWR_EN), 32'h0);
    check("rst_ready", 32'(READY), 32'h0);
    check("rst_fault", 32'(FAULT), 32'h0);
    check("rst_fidx", 32'(FAULT_IDX), 32'h0);
    RST = 1'b0;
    tick(3);

    // Power-up with PG tied high
    EN = 1'b1;
    tick(1);                                   // edge 0
    check("up_e0_pwr", 32'(PWR_EN), 32'h1);
    tick(4);                                   // edge 4
    check("up_e4_pwr", 32'(PWR_EN), 32'h1);
    tick(1);                                   // edge 5
    check("up_e5_pwr", 32'(PWR_EN), 32'h3);
    check("up_e5_rdy", 32'(READY), 32'h0);
    tick(4);                                   // edge 9
    check("up_e9_rdy", 32'(READY), 32'h0);
    tick(1);                                   // edge 10
    check("up_e10_rdy", 32'(READY), 32'h1);
    check("up_e10_pwr", 32'(PWR_EN), 32'h3);

    // Power-down from ON; EN re-raised during DOWN is ignored
    EN = 1'b0;
    tick(1);                                   // edge t
    check("dn_t_pwr", 32'(PWR_EN), 32'h1);
    check("dn_t_rdy", 32'(READY), 32'h0);
    tick(2);                                   // edge t+2
    check("dn_t2_pwr", 32'(PWR_EN), 32'h1);
    tick(1);                                   // edge t+3
    check("dn_t3_pwr", 32'(PWR_EN), 32'h0);
    EN = 1'b1;
    tick(3);                                   // edge t+6
    check("dn_t6_pwr", 32'(PWR_EN), 32'h0);
    check("dn_t6_fault", 32'(FAULT), 32'h0);
    tick(1);                                   // edge t+7: new edge 0
    check("dn_t7_pwr", 32'(PWR_EN), 32'h1);

    // Run up to ON again, then lose PG[1]
    tick(10);
    check("on2_rdy", 32'(READY), 32'h1);
    PG = 2'b01;
    tick(2);
    check("pgl_early_fault", 32'(FAULT), 32'h0);
    tick(1);
    check("pgl_fault", 32'(FAULT), 32'h1);
    check("pgl_fidx", 32'(FAULT_IDX), 32'h1);
    check("pgl_pwr", 32'(PWR_EN), 32'h0);
    check("pgl_rdy", 32'(READY), 32'h0);
    PG  = 2'b11;
    EN  = 1'b0;
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    check("pgl_clr", 32'(FAULT), 32'h0);

    // Timeout with PG[0] low
    PG = 2'b10;
    tick(3);
    EN = 1'b1;
    tick(1);                                   // edge 0
    check("to_e0_pwr", 32'(PWR_EN), 32'h1);
    tick(15);                                  // edge 15
    check("to_e15_fault", 32'(FAULT), 32'h0);
    check("to_e15_pwr", 32'(PWR_EN), 32'h1);
    tick(1);                                   // edge 16
    check("to_e16_fault", 32'(FAULT), 32'h1);
    check("to_e16_fidx", 32'(FAULT_IDX), 32'h0);
    check("to_e16_pwr", 32'(PWR_EN), 32'h0);
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    check("to_clr_en1", 32'(FAULT), 32'h1);
    EN = 1'b0;
    tick(1);
    check("to_hold_noclr", 32'(FAULT), 32'h1);
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    check("to_clr_en0", 32'(FAULT), 32'h0);

    // EN dropped during UP_SETTLE of domain 0
    PG = 2'b11;
    tick(3);
    EN = 1'b1;
    tick(1);                                   // edge 0
    check("us_e0_pwr", 32'(PWR_EN), 32'h1);
    tick(2);                                   // edge 2, settling
    EN = 1'b0;
    tick(1);                                   // edge 3
    check("us_drop_pwr", 32'(PWR_EN), 32'h0);
    check("us_drop_fault", 32'(FAULT), 32'h0);
    EN = 1'b1;
    tick(3);                                   // edge 6: reaches OFF
    check("us_e6_pwr", 32'(PWR_EN), 32'h0);
    tick(1);                                   // edge 7
    check("us_e7_pwr", 32'(PWR_EN), 32'h1);

    // Reset in UP_WAIT of domain 1 (PG[1] held low)
    PG = 2'b01;
    tick(5);
    check("rw_pwr", 32'(PWR_EN), 32'h3);
    tick(3);
    RST = 1'b1;
    tick(1);
    check("rw_rst_pwr", 32'(PWR_EN), 32'h0);
    check("rw_rst_rdy", 32'(READY), 32'h0);
    check("rw_rst_fault", 32'(FAULT), 32'h0);
    check("rw_rst_fidx", 32'(FAULT_IDX), 32'h0);
    RST = 1'b0;
    EN  = 1'b0;
    tick(1);
    check("rw_off_idle", 32'(PWR_EN), 32'h0);
    EN = 1'b1;
    tick(1);
    check("rw_off_restart", 32'(PWR_EN), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
